pc_next_unit: RTL
=================

// Module: pc_next_unit
// PURPOSE
//  Registered program-counter unit for the CPU fetch stage, generalised successor to the branch-target adder.
//  Holds PC and computes PC+4, branch (PC+4 + Imm<<2), jump and jump-register targets.
//  Adds stall and halt control, a boot cycle and a retired-instruction counter.
//  Sits between control/ALU (select, condition) and instruction memory (PC).
// PARAMETERS
//  ADDR_W     32            PC/immediate width; legal range 16..32
//  RESET_VEC  32'h0000_0000 PC value after reset (ADDR_W LSBs used)
//  TRAP_VEC   32'h0000_0080 PC loaded on misaligned target (PC_ALIGN_CHECK_EN only)
//  CNT_W      32            width of InstrCount
// PORTS
//  CLK          in   1       clock; all state updates on rising edge
//  Reset        in   1       synchronous, active-high reset
//  Stall        in   1       1 = hold PC, FSM and counter this cycle
//  Halt         in   1       1 = current instruction is HALT
//  PCSrc        in   2       00 seq, 01 branch, 10 jump, 11 jump-register
//  BranchTaken  in   1       branch condition (ALU zero etc.); used only when PCSrc=01
//  Imm          in   ADDR_W  sign-extended word offset (not yet shifted)
//  JumpAddr     in   26      J-type target field
//  RegAddr      in   ADDR_W  jump-register target (rs value)
//  PC           out  ADDR_W  current fetch address
//  PCPlus4      out  ADDR_W  PC+4, combinational from PC (link value)
//  PcValid      out  1       1 = PC is a real fetch (RUN state)
//  Halted       out  1       1 = FSM in HALT
//  InstrCount   out  CNT_W   retired-instruction count
//  Misaligned   out  1       sticky trap flag (PC_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  Reset (sync, high): PC=RESET_VEC, state=BOOT, PcValid=0, Halted=0, InstrCount=0, Misaligned=0.
//  Reset dominates all inputs, incl. mid-stall and in HALT; takes effect at that edge.
//  FSM: BOOT -> RUN unconditionally next edge (PC stays RESET_VEC; no retire, no count).
//   RUN: Stall=1 -> hold everything (Stall beats Halt and PCSrc).
//        Stall=0,Halt=1 -> HALT; PC holds at halt instr; counter +1 (halt retires).
//        Stall=0,Halt=0 -> PC<=NextPC; counter +1.
//   HALT: hold all state; exit only via Reset. PcValid=0, Halted=1.
//  NextPC (all arithmetic mod 2^ADDR_W, wrap silently):
//   00: PC+4.  01: BranchTaken ? PC+4+(Imm<<2) : PC+4.  10: {PCPlus4[ADDR_W-1:28],JumpAddr,2'b00};
//       for ADDR_W<=28 use {JumpAddr,2'b00}[ADDR_W-1:0].  11: RegAddr.
//  Imm<<2 drops top 2 bits of Imm; no overflow detect.
//  InstrCount saturates at all-ones (no wrap).
//  Latency: PC updates one edge after selects sampled; PCPlus4 zero-latency from PC.
// CONFIGURATION
//  Macro PC_ALIGN_CHECK_EN:
//   defined: in RUN with Stall=0,Halt=0, if NextPC[1:0]!=0 -> PC<=TRAP_VEC, Misaligned<=1
//     (sticky until Reset), counter +1. Normal target otherwise.
//   undefined: no check; NextPC loaded as is; Misaligned port tied 0.
// STRUCTURE
//  Header pc_next_unit_defs.vh: PCSrc encodings (PCSRC_SEQ/BR/J/JR), FSM state codes (ST_BOOT/RUN/HALT).
//  Sub-module pc_target_calc: combinational PC+4, branch, jump, JR targets and NextPC mux.
//  Top holds PC register, FSM, counter, align check.
// TESTING
//  Reset, RESET_VEC=0 -> cycle1 PC=0,PcValid=0; cycle2 PcValid=1; 3 seq edges -> PC=0xC, InstrCount=3.
//  PC=0x40, PCSrc=01, Imm=-2, BranchTaken=1 -> PC=0x3C; BranchTaken=0 -> PC=0x44.
//  PC=0xF0000010, PCSrc=10, JumpAddr=0x0000100 -> PC=0xF0000400; PCSrc=11, RegAddr=0x200 -> PC=0x200.
//  Stall=1 with Halt=1, PCSrc=10 for 2 cycles -> PC, InstrCount, state unchanged; release -> HALT, Halted=1.
//  In HALT toggle all inputs 10 cycles -> no change; Reset=1 -> PC=RESET_VEC, Halted=0, count 0.
//  PC_ALIGN_CHECK_EN, PCSrc=11, RegAddr=0x202 -> PC=TRAP_VEC, Misaligned=1; CNT_W=4 count saturates at 0xF.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared encodings for the PC unit: PCSrc select codes and FSM state type.
package pc_next_unit_pkg;
    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } pc_state_t;
endpackage

// File: rtl/pc_target_calc.sv
// Combinational PC+4, branch, jump and jump-register targets plus NextPC select.
// Zero latency; no flow control.
module pc_target_calc
    import pc_next_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] PC,
    input  logic [1:0]        PCSrc,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] Imm,
    input  logic [25:0]       JumpAddr,
    input  logic [ADDR_W-1:0] RegAddr,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic [ADDR_W-1:0] NextPC
);
    logic [ADDR_W-1:0] w_imm_sh;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_j_tgt;

    assign PCPlus4  = PC + ADDR_W'(4);
    // Top two Imm bits fall off the shift; the sum wraps modulo 2^ADDR_W.
    assign w_imm_sh = Imm << 2;
    assign w_br_tgt = PCPlus4 + w_imm_sh;

    generate
        if (ADDR_W > 28) begin : g_j_region
            assign w_j_tgt = {PCPlus4[ADDR_W-1:28], JumpAddr, 2'b00};
        end else begin : g_j_trunc
            logic [27:0] w_j_full;
            assign w_j_full = {JumpAddr, 2'b00};
            assign w_j_tgt  = w_j_full[ADDR_W-1:0];
        end
    endgenerate

    always_comb begin
        NextPC = PCPlus4;
        case (PCSrc)
            PCSRC_SEQ: NextPC = PCPlus4;
            PCSRC_BR:  NextPC = BranchTaken ? w_br_tgt : PCPlus4;
            PCSRC_J:   NextPC = w_j_tgt;
            PCSRC_JR:  NextPC = RegAddr;
            default:   NextPC = PCPlus4;
        endcase
    end
endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch PC with BOOT/RUN/HALT control, stall and saturating retire counter.
// Optional misaligned-target trap enabled by macro PC_ALIGN_CHECK_EN.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
`ifdef PC_ALIGN_CHECK_EN
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0080,
`endif
    parameter int          CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Halt,
    input  logic [1:0]        PCSrc,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] Imm,
    input  logic [25:0]       JumpAddr,
    input  logic [ADDR_W-1:0] RegAddr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              PcValid,
    output logic              Halted,
    output logic [CNT_W-1:0]  InstrCount,
    output logic              Misaligned
);
    localparam logic [ADDR_W-1:0] RST_PC = RESET_VEC[ADDR_W-1:0];

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_retire;
    logic              w_load;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
        .PC          (r_pc),
        .PCSrc       (PCSrc),
        .BranchTaken (BranchTaken),
        .Imm         (Imm),
        .JumpAddr    (JumpAddr),
        .RegAddr     (RegAddr),
        .PCPlus4     (PCPlus4),
        .NextPC      (w_next_pc)
    );

    // Stall outranks Halt and PCSrc; a HALT instruction retires but keeps its PC.
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!Stall) begin
                    w_retire = 1'b1;
                    if (Halt) w_state_nxt = ST_HALT;
                    else      w_load      = 1'b1;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_HALT;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;
    logic w_trap;
    assign w_trap     = w_load && (w_next_pc[1:0] != 2'b00);
    assign Misaligned = r_misaligned;

    always_ff @(posedge CLK) begin
        if (Reset)       r_misaligned <= 1'b0;
        else if (w_trap) r_misaligned <= 1'b1;
    end
`else
    logic w_trap;
    assign w_trap     = 1'b0;
    assign Misaligned = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RST_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
`ifdef PC_ALIGN_CHECK_EN
                r_pc <= w_trap ? TRAP_VEC[ADDR_W-1:0] : w_next_pc;
`else
                r_pc <= w_trap ? RST_PC : w_next_pc;
`endif
            end
            if (w_retire && (r_cnt != '1))
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign PC         = r_pc;
    assign PcValid    = (r_state == ST_RUN);
    assign Halted     = (r_state == ST_HALT);
    assign InstrCount = r_cnt;
endmodule
